// File: rtl/gp_tag_stage_pkg.sv
// Shared router constants: flit packet-ID width and network-wide golden-epoch defaults.
// Every router instance imports these so that all epoch counters agree.
// No logic; constants only.
package gp_tag_stage_pkg;
    localparam int FLITNUM_SIZE  = 8;
    localparam int NODE_NUM_DEF  = 16;
    localparam int SRC_W_DEF     = 4;
    localparam int EPOCH_LEN_DEF = 64;
endpackage

// File: rtl/gp_flit_reg.sv
// Per-port flit register with golden-source compare.
// Latency 1 cycle; payload fields hold while the slot is empty.
// No backpressure: accepts one flit every cycle.
module gp_flit_reg #(
    parameter int SRC_W  = 4,
    parameter int PID_W  = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [SRC_W-1:0]  in_src,
    input  logic [PID_W-1:0]  in_pid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SRC_W-1:0]  golden_src,
    output logic              valid,
    output logic              gp,
    output logic [PID_W-1:0]  pid,
    output logic [SRC_W-1:0]  src,
    output logic [DATA_W-1:0] data
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            gp    <= 1'b0;
            pid   <= '0;
            src   <= '0;
            data  <= '0;
        end else begin
            valid <= in_valid;
            // golden_src here is the value of the sampling cycle, so a flit
            // arriving on the last epoch cycle is tagged against the old source.
            gp    <= in_valid && (in_src == golden_src);
            if (in_valid) begin
                pid  <= in_pid;
                src  <= in_src;
                data <= in_data;
            end
        end
    end
endmodule

// File: rtl/gp_tag_stage.sv
// Arbiter input stage: registers both ports and tags Golden Packets from the epoch counter.
// Latency 1 cycle, throughput 1 flit/port/cycle.
// Never stalls; epoch_en=0 only freezes the epoch counter.
module gp_tag_stage
    import gp_tag_stage_pkg::*;
#(
    parameter int NODE_NUM  = NODE_NUM_DEF,
    parameter int SRC_W     = SRC_W_DEF,
    parameter int PID_W     = FLITNUM_SIZE,
    parameter int DATA_W    = 32,
    parameter int EPOCH_LEN = EPOCH_LEN_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              epoch_en,
    input  logic              in_valid0,
    input  logic              in_valid1,
    input  logic [SRC_W-1:0]  in_src0,
    input  logic [SRC_W-1:0]  in_src1,
    input  logic [PID_W-1:0]  in_pid0,
    input  logic [PID_W-1:0]  in_pid1,
    input  logic [DATA_W-1:0] in_data0,
    input  logic [DATA_W-1:0] in_data1,
    output logic              valid0,
    output logic              valid1,
    output logic              GP0,
    output logic              GP1,
    output logic [PID_W-1:0]  inPktID0,
    output logic [PID_W-1:0]  inPktID1,
    output logic [SRC_W-1:0]  out_src0,
    output logic [SRC_W-1:0]  out_src1,
    output logic [DATA_W-1:0] out_data0,
    output logic [DATA_W-1:0] out_data1,
    output logic [SRC_W-1:0]  golden_src,
    output logic              epoch_start
);
    localparam int               EP_W    = $clog2(EPOCH_LEN);
    localparam logic [EP_W-1:0]  EP_LAST = EP_W'(EPOCH_LEN - 1);
    localparam logic [SRC_W-1:0] SRC_MAX = SRC_W'(NODE_NUM - 1);

    logic [EP_W-1:0] ep_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ep_cnt      <= '0;
            golden_src  <= '0;
            epoch_start <= 1'b0;
        end else if (epoch_en) begin
            if (ep_cnt == EP_LAST) begin
                ep_cnt      <= '0;
                golden_src  <= (golden_src == SRC_MAX) ? '0 : golden_src + SRC_W'(1);
                epoch_start <= 1'b1;
            end else begin
                ep_cnt      <= ep_cnt + EP_W'(1);
                epoch_start <= 1'b0;
            end
        end else begin
            // Frozen epoch: count and source hold, but a pulse must not stretch.
            epoch_start <= 1'b0;
        end
    end

    gp_flit_reg #(.SRC_W(SRC_W), .PID_W(PID_W), .DATA_W(DATA_W)) u_port0 (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid0),
        .in_src     (in_src0),
        .in_pid     (in_pid0),
        .in_data    (in_data0),
        .golden_src (golden_src),
        .valid      (valid0),
        .gp         (GP0),
        .pid        (inPktID0),
        .src        (out_src0),
        .data       (out_data0)
    );

    gp_flit_reg #(.SRC_W(SRC_W), .PID_W(PID_W), .DATA_W(DATA_W)) u_port1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid1),
        .in_src     (in_src1),
        .in_pid     (in_pid1),
        .in_data    (in_data1),
        .golden_src (golden_src),
        .valid      (valid1),
        .gp         (GP1),
        .pid        (inPktID1),
        .src        (out_src1),
        .data       (out_data1)
    );
endmodule
